// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants for the execute-stage sequencer in front of the Cpu16Lite ALU.
// Op codes match the ALU decode; ALU_OP_NOP lands in the ALU default branch,
// so the ALU holds its outputs and carry while it is presented.
package alu_exec_ctrl_pkg;

  localparam int ALU_OPID_WIDTH = 4;

  typedef logic [ALU_OPID_WIDTH-1:0] alu_opid_t;

  localparam alu_opid_t ALU_OP_ADD  = 4'h0;
  localparam alu_opid_t ALU_OP_ADC  = 4'h1;
  localparam alu_opid_t ALU_OP_SUB  = 4'h2;
  localparam alu_opid_t ALU_OP_SBC  = 4'h3;
  localparam alu_opid_t ALU_OP_AND  = 4'h4;
  localparam alu_opid_t ALU_OP_OR   = 4'h5;
  localparam alu_opid_t ALU_OP_XOR  = 4'h6;
  localparam alu_opid_t ALU_OP_CMP  = 4'h7;
  localparam alu_opid_t ALU_OP_TEST = 4'h8;
  localparam alu_opid_t ALU_OP_SETF = 4'h9;
  localparam alu_opid_t ALU_OP_RLC  = 4'hA;
  localparam alu_opid_t ALU_OP_NOP  = 4'hF;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction issue handshake between the decoder (master) and the sequencer (slave).
interface alu_exec_ctrl_if #(
  parameter int BITS     = 16,
  parameter int REG_BITS = 3
);
  import alu_exec_ctrl_pkg::*;

  logic                in_valid;
  logic                in_ready;
  alu_opid_t           in_op_id;
  logic [REG_BITS-1:0] in_rd;
  logic [REG_BITS-1:0] in_rs1;
  logic [REG_BITS-1:0] in_rs2;
  logic                in_use_imm;
  logic [BITS-1:0]     in_imm;
  logic                in_wb;

  modport master (
    output in_valid, in_op_id, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_wb,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op_id, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_wb,
    output in_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two async operand read ports, one async debug port,
// one synchronous write port. R0 is an ordinary register.
module alu_regfile #(
  parameter int BITS     = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [REG_BITS-1:0] rs1_addr,
  output logic [BITS-1:0]     rs1_data,
  input  logic [REG_BITS-1:0] rs2_addr,
  output logic [BITS-1:0]     rs2_data,
  input  logic [REG_BITS-1:0] dbg_addr,
  output logic [BITS-1:0]     dbg_data,
  input  logic                we,
  input  logic [REG_BITS-1:0] wr_addr,
  input  logic [BITS-1:0]     wr_data
);

  localparam int NREG = 1 << REG_BITS;

  logic [BITS-1:0] regs_q [NREG];
  logic [BITS-1:0] regs_d [NREG];

  // next register contents: single write port
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wr_addr] = wr_data;
  end

  // storage, cleared by async reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: latches operands into the ALU input registers,
// holds the op for exactly one cycle, then commits result and flags.
// A new instruction may be accepted on the commit edge; its operands are
// forwarded from the committing result when they name the pending rd.
//
//   state | meaning
//   IDLE  | nothing in flight, ready for an instruction
//   EXEC  | ALU inputs valid, op presented for this cycle only
//   WB    | ALU outputs valid, commit on the closing edge, may accept next
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int BITS     = 16,
  parameter int REG_BITS = 3
) (
  input  logic                      clk,
  input  logic                      nreset,
  alu_exec_ctrl_if.slave            in_if,
  output logic [ALU_OPID_WIDTH-1:0] alu_op_id,
  output logic [BITS-1:0]           alu_op1,
  output logic [BITS-1:0]           alu_op2,
  input  logic [BITS-1:0]           alu_out,
  input  logic                      alu_z,
  input  logic                      alu_c,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic                      done,
  input  logic [REG_BITS-1:0]       dbg_addr,
  output logic [BITS-1:0]           dbg_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]          state_q, state_d;
  alu_opid_t           op_id_q, op_id_d;
  logic [BITS-1:0]     op1_q, op1_d;
  logic [BITS-1:0]     op2_q, op2_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                wb_q, wb_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
  logic                done_q, done_d;

  logic                in_ready;
  logic                accept;
  logic                fwd_ok;
  logic                commit;
  logic [BITS-1:0]     rf_rs1_data;
  logic [BITS-1:0]     rf_rs2_data;
  logic [BITS-1:0]     src1;
  logic [BITS-1:0]     src2;

  alu_regfile #(
    .BITS     (BITS),
    .REG_BITS (REG_BITS)
  ) u_regfile (
    .clk      (clk),
    .nreset   (nreset),
    .rs1_addr (in_if.in_rs1),
    .rs1_data (rf_rs1_data),
    .rs2_addr (in_if.in_rs2),
    .rs2_data (rf_rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (commit && wb_q),
    .wr_addr  (rd_q),
    .wr_data  (alu_out)
  );

  assign in_ready       = (state_q != ST_EXEC);
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign commit         = (state_q == ST_WB);
  // the register file still holds the old value during WB, so bypass it
  assign fwd_ok         = commit && wb_q;

  // operand selection with forwarding of the committing result
  always_comb begin
    src1 = rf_rs1_data;
    src2 = in_if.in_use_imm ? in_if.in_imm : rf_rs2_data;
    if (fwd_ok && (in_if.in_rs1 == rd_q)) src1 = alu_out;
    if (fwd_ok && !in_if.in_use_imm && (in_if.in_rs2 == rd_q)) src2 = alu_out;
  end

  // sequencer next-state, ALU input and commit logic
  always_comb begin
    state_d  = state_q;
    op_id_d  = op_id_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // op must drop after one cycle so stateful ops never run twice
        op_id_d = ALU_OP_NOP;
        state_d = ST_WB;
      end
      ST_WB: begin
        flag_z_d = alu_z;
        flag_c_d = alu_c;
        done_d   = 1'b1;
        state_d  = accept ? ST_EXEC : ST_IDLE;
      end
      default: begin
        op_id_d = ALU_OP_NOP;
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      op_id_d = in_if.in_op_id;
      op1_d   = src1;
      op2_d   = src2;
      rd_d    = in_if.in_rd;
      wb_d    = in_if.in_wb;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      op_id_q  <= ALU_OP_NOP;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_id_q  <= op_id_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      done_q   <= done_d;
    end
  end

  assign alu_op_id = op_id_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural one-cycle ALU, sequential ISA reference
// model feeding a scoreboard that is checked on every done pulse.
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  localparam int BITS = 16;
  localparam int REG_BITS = 3;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.BITS(BITS), .REG_BITS(REG_BITS)) bus ();

  logic [3:0]  alu_op_id;
  logic [15:0] alu_op1, alu_op2, alu_out;
  logic        alu_z, alu_c, flag_z, flag_c, done;
  logic [2:0]  dbg_addr, mon_addr, tb_addr;
  logic        use_mon;
  logic [15:0] dbg_data;

  assign dbg_addr = use_mon ? mon_addr : tb_addr;

  alu_exec_ctrl #(.BITS(BITS), .REG_BITS(REG_BITS)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_if     (bus.slave),
    .alu_op_id (alu_op_id),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .done      (done),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic        z;
    logic        c;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_r [NREG];
  logic        ref_c;

  // returns {z, c, out}; unknown ops (NOP) hold previous outputs
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin,
                                         input logic [15:0] oldv, input logic oldz);
    logic [16:0] s;
    logic        c;
    s = '0;
    c = cin;
    case (op)
      ALU_OP_ADD: begin s = {1'b0, a} + {1'b0, b}; c = s[16]; end
      ALU_OP_ADC: begin s = {1'b0, a} + {1'b0, b} + {16'd0, cin}; c = s[16]; end
      ALU_OP_SUB, ALU_OP_CMP: begin s = {1'b0, a} - {1'b0, b}; c = s[16]; end
      ALU_OP_AND, ALU_OP_TEST: s = {1'b0, a & b};
      ALU_OP_OR:  s = {1'b0, a | b};
      ALU_OP_XOR: s = {1'b0, a ^ b};
      default: return {oldz, cin, oldv};
    endcase
    return {(s[15:0] == 16'd0), c, s[15:0]};
  endfunction

  // behavioural ALU with one-cycle registered latency and internal carry
  always @(posedge clk or negedge nreset) begin
    if (!nreset) {alu_z, alu_c, alu_out} <= '0;
    else         {alu_z, alu_c, alu_out} <= alu_fn(alu_op_id, alu_op1, alu_op2, alu_c, alu_out, alu_z);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor and op-held-too-long checker
  initial begin : monitor
    exp_t e;
    logic [3:0] prev_op;
    use_mon = 1'b0;
    mon_addr = '0;
    prev_op = ALU_OP_NOP;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        prev_op = ALU_OP_NOP;
      end else begin
        if (prev_op != ALU_OP_NOP) begin
          checks++;
          if (alu_op_id !== ALU_OP_NOP) begin
            failures++;
            $display("FAIL op_held actual=%h required=%h", alu_op_id, ALU_OP_NOP);
          end
        end
        prev_op = alu_op_id;
        if (done === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
          end else begin
            e = sb.pop_front();
            if (cyc - e.acc != 2) begin
              failures++;
              $display("FAIL latency actual=%0d required=2", cyc - e.acc);
            end
            checks++;
            if (flag_z !== e.z) begin
              failures++;
              $display("FAIL commit_flag_z actual=%b required=%b", flag_z, e.z);
            end
            checks++;
            if (flag_c !== e.c) begin
              failures++;
              $display("FAIL commit_flag_c actual=%b required=%b", flag_c, e.c);
            end
            use_mon = 1'b1;
            mon_addr = e.rd;
            #1;
            checks++;
            if (dbg_data !== e.val) begin
              failures++;
              $display("FAIL commit_reg R%0d actual=%h required=%h", e.rd, dbg_data, e.val);
            end
            use_mon = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench hung");
  end

  // issue one instruction; called at a negedge, returns at the negedge of its EXEC cycle
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm,
                      input logic wb);
    int n;
    logic [17:0] r;
    logic [15:0] b;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_op_id = op;
    bus.in_rd = rd;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_use_imm = use_imm;
    bus.in_imm = imm;
    bus.in_wb = wb;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    b = use_imm ? imm : ref_r[rs2];
    r = alu_fn(op, ref_r[rs1], b, ref_c, 16'd0, 1'b0);
    ref_c = r[16];
    if (wb) ref_r[rd] = r[15:0];
    @(negedge clk);
    e.rd = rd;
    e.val = ref_r[rd];
    e.z = r[17];
    e.c = r[16];
    e.acc = cyc;
    sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wait_done actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    nreset = 1'b0;
    sb.delete();
    for (int i = 0; i < NREG; i++) ref_r[i] = '0;
    ref_c = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready actual=%b required=1", tag, bus.in_ready);
    end
    checks++;
    if (alu_op_id !== ALU_OP_NOP) begin
      failures++;
      $display("FAIL %s_op_id actual=%h required=%h", tag, alu_op_id, ALU_OP_NOP);
    end
    checks++;
    if ({flag_z, flag_c, done} !== 3'b000) begin
      failures++;
      $display("FAIL %s_flags_done actual=%b required=000", tag, {flag_z, flag_c, done});
    end
    checks++;
    if ({alu_op1, alu_op2} !== 32'd0) begin
      failures++;
      $display("FAIL %s_operands actual=%h required=0", tag, {alu_op1, alu_op2});
    end
    for (int i = 0; i < NREG; i++) begin
      tb_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 16'd0) begin
        failures++;
        $display("FAIL %s_reg R%0d actual=%h required=0", tag, i, dbg_data);
      end
    end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_after actual=%b required=1", tag, bus.in_ready);
    end
  endtask

  task automatic test_or();
    send(ALU_OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b1);
    checks++;
    if (alu_op_id !== ALU_OP_OR || alu_op1 !== 16'h0000 || alu_op2 !== 16'h0005) begin
      failures++;
      $display("FAIL or_exec_inputs actual=%h/%h/%h required=%h/0000/0005",
               alu_op_id, alu_op1, alu_op2, ALU_OP_OR);
    end
  endtask

  task automatic test_back_to_back();
    send(ALU_OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'hFFFF, 1'b1);
    checks++;
    if (alu_op1 !== 16'h0005 || alu_op2 !== 16'hFFFF) begin
      failures++;
      $display("FAIL fwd_rs1 actual=%h/%h required=0005/ffff", alu_op1, alu_op2);
    end
    wait_idle();
    tb_addr = 3'd2;
    #1;
    checks++;
    if (dbg_data !== 16'h0004 || flag_c !== 1'b1) begin
      failures++;
      $display("FAIL b2b_result actual=%h,c=%b required=0004,c=1", dbg_data, flag_c);
    end
  endtask

  task automatic test_cmp();
    send(ALU_OP_CMP, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0005, 1'b0);
    wait_idle();
    tb_addr = 3'd1;
    #1;
    checks++;
    if (flag_z !== 1'b1 || flag_c !== 1'b0 || dbg_data !== 16'h0005) begin
      failures++;
      $display("FAIL cmp actual=z%b,c%b,R1=%h required=z1,c0,R1=0005", flag_z, flag_c, dbg_data);
    end
  endtask

  task automatic test_adc();
    send(ALU_OP_ADD, 3'd4, 3'd2, 3'd0, 1'b1, 16'hFFFF, 1'b1);
    wait_idle();
    checks++;
    if (flag_c !== 1'b1) begin
      failures++;
      $display("FAIL adc_setup_c actual=%b required=1", flag_c);
    end
    send(ALU_OP_ADC, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001, 1'b1);
    checks++;
    if (alu_op_id !== ALU_OP_ADC) begin
      failures++;
      $display("FAIL adc_exec_op actual=%h required=%h", alu_op_id, ALU_OP_ADC);
    end
    @(negedge clk);
    checks++;
    if (alu_op_id !== ALU_OP_NOP) begin
      failures++;
      $display("FAIL adc_wb_op actual=%h required=%h", alu_op_id, ALU_OP_NOP);
    end
    wait_idle();
    tb_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 16'h0002) begin
      failures++;
      $display("FAIL adc_result actual=%h required=0002", dbg_data);
    end
  endtask

  task automatic test_fwd_rs2();
    send(ALU_OP_AND, 3'd6, 3'd1, 3'd0, 1'b1, 16'h000F, 1'b1);
    send(ALU_OP_SUB, 3'd7, 3'd4, 3'd6, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (alu_op1 !== 16'h0003 || alu_op2 !== 16'h0005) begin
      failures++;
      $display("FAIL fwd_rs2 actual=%h/%h required=0003/0005", alu_op1, alu_op2);
    end
    wait_idle();
    tb_addr = 3'd7;
    #1;
    checks++;
    if (dbg_data !== 16'hFFFE || flag_c !== 1'b1) begin
      failures++;
      $display("FAIL sub_borrow actual=%h,c=%b required=fffe,c=1", dbg_data, flag_c);
    end
  endtask

  task automatic test_reset_mid_exec();
    send(ALU_OP_ADD, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b1);
    nreset = 1'b0;
    sb.delete();
    for (int i = 0; i < NREG; i++) ref_r[i] = '0;
    ref_c = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL abandon_done actual=%b required=0", done);
      end
    end
    tb_addr = 3'd5;
    #1;
    checks++;
    if (dbg_data !== 16'h0000 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abandon_state actual=R5=%h,rdy=%b required=R5=0000,rdy=1", dbg_data, bus.in_ready);
    end
  endtask

  initial begin : main
    bus.in_valid = 1'b0;
    bus.in_op_id = ALU_OP_NOP;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm = '0;
    bus.in_wb = 1'b0;
    tb_addr = '0;
    test_reset("power_on");
    test_or();
    test_back_to_back();
    test_cmp();
    test_adc();
    test_fwd_rs2();
    test_reset_mid_exec();
    send(ALU_OP_OR, 3'd2, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b1);
    wait_idle();
    test_reset("mid_run");
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage sequencer directly upstream of the Cpu16Lite ALU.
- Accepts decoded ALU instructions over a valid/ready handshake.
- Reads operands from an internal register file and drives the registered ALU inputs.
- Waits the ALU's one-cycle latency, then commits the result to the register file and latches the z/c flags.
- Forwards the committing result to a back-to-back instruction.

Parameters:
BITS, 16, datapath width; must match the ALU instance.
REG_BITS, 3, register address width (2**REG_BITS registers).

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted on edge where in_valid&in_ready
in_op_id  in  ALU_OPID_WIDTH  ALU operation code
in_rd  in  REG_BITS  destination register
in_rs1  in  REG_BITS  source register, drives op1
in_rs2  in  REG_BITS  source register, drives op2 when in_use_imm=0
in_use_imm  in  1  op2 taken from in_imm
in_imm  in  BITS  immediate operand
in_wb  in  1  write result to in_rd (0 for TEST/CMP)
alu_op_id  out  ALU_OPID_WIDTH  to ALU op_id
alu_op1  out  BITS  to ALU op1
alu_op2  out  BITS  to ALU op2
alu_out  in  BITS  from ALU out
alu_z  in  1  from ALU z
alu_c  in  1  from ALU c
flag_z  out  1  committed zero flag
flag_c  out  1  committed carry flag
done  out  1  one-cycle pulse on commit edge
dbg_addr  in  REG_BITS  debug read address
dbg_data  out  BITS  combinational register read

Behaviour:
- Reset (async, nreset=0): state IDLE; all registers=0; alu_op_id=ALU_OP_NOP; alu_op1=alu_op2=0; flag_z=flag_c=0; done=0; pending rd/wb cleared.
- States:
  - IDLE: in_ready=1. On handshake, register alu_op1=R[rs1]; register alu_op2=in_use_imm ? in_imm : R[rs2]; register alu_op_id, rd, wb; go to EXEC.
  - EXEC: in_ready=0. alu_op_id=the latched op for exactly this cycle; the ALU computes at the end of this cycle. Next state WB.
  - WB: alu_out/alu_z/alu_c are valid. alu_op_id=ALU_OP_NOP, which is mandatory so ADC/SBC/SETF/RLC are never executed twice. in_ready=1.
    - At the end edge: if wb, R[rd]<=alu_out; flag_z<=alu_z; flag_c<=alu_c; done=1 for that cycle.
    - If a handshake occurs on the same edge, go to EXEC with the new operands; otherwise go to IDLE.
- Forwarding, WB state only: if pending wb=1 and rs1==rd, op1 takes alu_out; the same applies to rs2 when not immediate. Otherwise operands come from R[].
- alu_op_id is ALU_OP_NOP in every state except EXEC.
- Latency: accept edge -> commit edge = 2 cycles. Throughput: one instruction per 2 cycles.
- Flags update on every commit, including wb=0. Flag update is independent of register write.
- Reset mid-EXEC or mid-WB: instruction abandoned, no register write, no done pulse.
- The register file has no hardwired zero register; R0 is an ordinary register.
- dbg_data shows committed contents only, with no forwarding.
- in_valid while in_ready=0 is ignored and held by the upstream.

Decomposition:
- alu.vh gains ALU_OP_NOP, an op code falling into the ALU default branch.
- Existing ALU_OPID_WIDTH and op codes are reused.
- FSM state encodings are local constants.
- One sub-module: alu_regfile, with 2 async read ports, 1 debug read port, 1 sync write port, and async reset clearing all entries.

Test Plan:
- Reset with nreset=0 mid-run -> state IDLE, in_ready=1, alu_op_id=ALU_OP_NOP, flag_z=flag_c=0, dbg_data=0 for all addresses.
- OR rd=1, rs1=0, imm=0x0005, wb=1 -> done exactly 2 cycles after accept; R1=0x0005; flag_z=0.
- Back-to-back ADD rd=2, rs1=1, imm=0xFFFF, accepted in the WB cycle of the previous instruction -> forwarding gives op1=0x0005; R2=0x0004; flag_c=1.
- CMP rs1=1, imm=0x0005, wb=0 -> flag_z=1, flag_c=0; R1 unchanged.
- With c=1, ADC rd=3, rs1=0, imm=0x0001 -> R3=0x0002, not 0x0003; alu_op_id=ALU_OP_NOP during WB.
- Accept ADD, then drop nreset during EXEC -> no done pulse; destination register keeps its old value; in_ready=1 after release.
